// File: rtl/mips_pc_sequencer.sv
// -----------------------------------------------------------------------------
// mips_pc_sequencer
//
// Program-counter sequencer for the single-cycle MIPS core. It selects the next
// PC from stall / return / call / jump / branch / increment, and keeps a
// circular hardware return-address stack (RAS) for call/return.
//
// Parameters:
//   PC_W       PC / instruction-address width in bits (1..26)
//   RAS_DEPTH  return-address stack entries (power of two, >= 2)
//   RESET_PC   PC value loaded on reset
//
// Ports:
//   clk            clock, all state updates on posedge
//   rst            synchronous active-high reset
//   stall          hold PC and RAS this cycle
//   jump           unconditional jump to jaddress
//   call           push pc+1, then jump to jaddress
//   ret            pop RAS into pc
//   branch_taken   pc <= pc + 1 + sext(branch_offset)
//   branch_offset  signed word offset relative to pc+1
//   jaddress       jump/call target, low PC_W bits used
//   pc             current PC (registered)
//   pc_plus1       pc + 1 modulo 2^PC_W (combinational link value)
//   ras_top        entry at stack top, 0 when empty (combinational)
//   ras_count      number of valid stack entries (registered)
//   ras_overflow   sticky: push while full
//   ras_underflow  sticky: pop while empty
// -----------------------------------------------------------------------------
module mips_pc_sequencer #(
  parameter int unsigned     PC_W      = 10,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  localparam int unsigned    CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic             branch_taken,
  input  logic [15:0]      branch_offset,
  input  logic [25:0]      jaddress,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus1,
  output logic [PC_W-1:0]  ras_top,
  output logic [CNT_W-1:0] ras_count,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned SUM_W = 32;

  // Stack storage and top-of-stack pointer
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;

  // Next-state signals
  logic [PC_W-1:0]  pc_nxt;
  logic [PTR_W-1:0] top_ptr_nxt;
  logic [CNT_W-1:0] ras_count_nxt;
  logic             ras_overflow_nxt;
  logic             ras_underflow_nxt;
  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr;
  logic [PC_W-1:0]  wr_data;

  // Derived values
  logic             ras_empty;
  logic             ras_full;
  logic [PC_W-1:0]  jump_target;
  logic [PC_W-1:0]  branch_target;
  logic [PTR_W-1:0] push_ptr;
  logic [PTR_W-1:0] pop_ptr;

  // Only the low PC_W bits of the jump target are architecturally used
  if (PC_W < 26) begin : g_jaddr_hi
    logic unused_jaddr_hi;
    assign unused_jaddr_hi = ^jaddress[25:PC_W];
  end

  assign pc_plus1    = pc + PC_W'(1);
  assign ras_empty   = (ras_count == '0);
  assign ras_full    = (ras_count == CNT_W'(RAS_DEPTH));
  assign ras_top     = ras_empty ? '0 : ras_mem[top_ptr];
  assign jump_target = jaddress[PC_W-1:0];
  assign push_ptr    = top_ptr + PTR_W'(1);
  assign pop_ptr     = top_ptr - PTR_W'(1);

  // Branch target: widen, add sign-extended offset, truncate (wraps both ways)
  assign branch_target = PC_W'(SUM_W'(pc_plus1) + SUM_W'(signed'(branch_offset)));

  // Next-PC selection and stack bookkeeping, highest priority first
  always_comb begin
    pc_nxt            = pc;
    top_ptr_nxt       = top_ptr;
    ras_count_nxt     = ras_count;
    ras_overflow_nxt  = ras_overflow;
    ras_underflow_nxt = ras_underflow;
    wr_en             = 1'b0;
    wr_ptr            = push_ptr;
    wr_data           = pc_plus1;

    if (!stall) begin
      if (ret && call) begin
        if (ras_empty) begin
          // Nothing to return to: fall through and still record the link
          pc_nxt            = pc_plus1;
          wr_en             = 1'b1;
          wr_ptr            = push_ptr;
          top_ptr_nxt       = push_ptr;
          ras_count_nxt     = CNT_W'(1);
          ras_underflow_nxt = 1'b1;
        end else begin
          // Swap: return to top and replace it with the new link in place
          pc_nxt = ras_top;
          wr_en  = 1'b1;
          wr_ptr = top_ptr;
        end
      end else if (ret) begin
        if (ras_empty) begin
          pc_nxt            = pc_plus1;
          ras_underflow_nxt = 1'b1;
        end else begin
          pc_nxt        = ras_top;
          top_ptr_nxt   = pop_ptr;
          ras_count_nxt = ras_count - CNT_W'(1);
        end
      end else if (call) begin
        // Push overwrites the oldest entry when full; count saturates
        pc_nxt      = jump_target;
        wr_en       = 1'b1;
        wr_ptr      = push_ptr;
        top_ptr_nxt = push_ptr;
        if (ras_full) begin
          ras_overflow_nxt = 1'b1;
        end else begin
          ras_count_nxt = ras_count + CNT_W'(1);
        end
      end else if (jump) begin
        pc_nxt = jump_target;
      end else if (branch_taken) begin
        pc_nxt = branch_target;
      end else begin
        pc_nxt = pc_plus1;
      end
    end
  end

  // PC, pointer, count and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      top_ptr       <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_nxt;
      top_ptr       <= top_ptr_nxt;
      ras_count     <= ras_count_nxt;
      ras_overflow  <= ras_overflow_nxt;
      ras_underflow <= ras_underflow_nxt;
    end
  end

  // Stack contents are not cleared; reset only suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      ras_mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mips_pc_sequencer.sv
module tb_mips_pc_sequencer;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned CNT_W     = $clog2(RAS_DEPTH + 1);
  localparam int          PC_MASK   = (1 << PC_W) - 1;
  localparam int          PC4_MASK  = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             jump;
  logic             call;
  logic             ret;
  logic             branch_taken;
  logic [15:0]      branch_offset;
  logic [25:0]      jaddress;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_plus1;
  logic [PC_W-1:0]  ras_top;
  logic [CNT_W-1:0] ras_count;
  logic             ras_overflow;
  logic             ras_underflow;

  logic [3:0]       pc4;
  logic [3:0]       pc4_plus1;
  logic [3:0]       ras_top4;
  logic [2:0]       ras_count4;
  logic             ras_overflow4;
  logic             ras_underflow4;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_ovf;
  bit m_unf;
  int m4_pc;

  always #5 clk = ~clk;

  mips_pc_sequencer #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .call(call), .ret(ret),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jaddress(jaddress),
    .pc(pc), .pc_plus1(pc_plus1), .ras_top(ras_top), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  // Narrow instance, free running, used for the wrap-around check
  mips_pc_sequencer #(.PC_W(4), .RAS_DEPTH(4), .RESET_PC('0)) dut4 (
    .clk(clk), .rst(rst), .stall(1'b0), .jump(1'b0), .call(1'b0), .ret(1'b0),
    .branch_taken(1'b0), .branch_offset(16'h0000), .jaddress(26'h0),
    .pc(pc4), .pc_plus1(pc4_plus1), .ras_top(ras_top4), .ras_count(ras_count4),
    .ras_overflow(ras_overflow4), .ras_underflow(ras_underflow4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit s, input bit c, input bit r, input bit j,
                        input bit b, input int ja, input int off);
    stall         = s;
    call          = c;
    ret           = r;
    jump          = j;
    branch_taken  = b;
    jaddress      = 26'(ja);
    branch_offset = 16'(off);
  endtask

  // Advance the model by the architectural rules, clock the DUT, compare all outputs
  task automatic tick(input string ph);
    int p1;
    int top;
    p1 = (m_pc + 1) & PC_MASK;
    if (rst) begin
      m_pc = 0;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (!stall) begin
      if (ret && call) begin
        if (m_stk.size() == 0) begin
          m_stk.push_back(p1);
          m_pc  = p1;
          m_unf = 1;
        end else begin
          m_pc = m_stk[$];
          m_stk[$] = p1;
        end
      end else if (ret) begin
        if (m_stk.size() == 0) begin
          m_pc  = p1;
          m_unf = 1;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else if (call) begin
        m_stk.push_back(p1);
        if (m_stk.size() > int'(RAS_DEPTH)) begin
          void'(m_stk.pop_front());
          m_ovf = 1;
        end
        m_pc = int'(jaddress) & PC_MASK;
      end else if (jump) begin
        m_pc = int'(jaddress) & PC_MASK;
      end else if (branch_taken) begin
        m_pc = (m_pc + 1 + int'(signed'(branch_offset))) & PC_MASK;
      end else begin
        m_pc = p1;
      end
    end
    m4_pc = rst ? 0 : ((m4_pc + 1) & PC4_MASK);

    @(posedge clk);
    #1;
    top = (m_stk.size() == 0) ? 0 : m_stk[$];
    check({ph, ".pc"},        32'(pc),            m_pc);
    check({ph, ".pc_plus1"},  32'(pc_plus1),      (m_pc + 1) & PC_MASK);
    check({ph, ".ras_top"},   32'(ras_top),       top);
    check({ph, ".ras_count"}, 32'(ras_count),     m_stk.size());
    check({ph, ".ovf"},       32'(ras_overflow),  32'(m_ovf));
    check({ph, ".unf"},       32'(ras_underflow), 32'(m_unf));
    check({ph, ".pc4"},       32'(pc4),           m4_pc);
  endtask

  initial begin
    m_pc  = 0;
    m_ovf = 0;
    m_unf = 0;
    m4_pc = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);

    // Reset, then free increment; narrow instance wraps 15 -> 0
    rst = 1'b1;
    tick("reset");
    check("reset_pc", 32'(pc), 0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) tick("incr");
    check("incr_pc17", 32'(pc), 17);
    check("wrap_pc4", 32'(pc4), 1);

    // Branch sign extension and wrap
    set_in(0, 0, 0, 1, 0, 20, 0);      tick("br_setup");
    set_in(0, 0, 0, 0, 1, 0, 16'hFFFA); tick("br_neg");
    check("br_neg_abs", 32'(pc), 15);
    set_in(0, 0, 0, 1, 0, 1020, 0);    tick("br_setup2");
    set_in(0, 0, 0, 0, 1, 0, 5);       tick("br_wrap");
    check("br_wrap_abs", 32'(pc), 2);

    // Nested call / return
    set_in(0, 0, 0, 1, 0, 10, 0);  tick("cr_setup");
    set_in(0, 1, 0, 0, 0, 100, 0); tick("call1");
    check("call1_top", 32'(ras_top), 11);
    set_in(0, 0, 0, 1, 0, 105, 0); tick("cr_jump");
    set_in(0, 1, 0, 0, 0, 200, 0); tick("call2");
    check("call2_top", 32'(ras_top), 106);
    set_in(0, 0, 1, 0, 0, 0, 0);   tick("ret1");
    check("ret1_pc", 32'(pc), 106);
    tick("ret2");
    check("ret2_pc", 32'(pc), 11);

    // Overflow then underflow
    set_in(0, 0, 0, 1, 0, 1, 0); tick("ovf_setup");
    for (int i = 1; i <= 5; i++) begin
      set_in(0, 1, 0, 0, 0, i + 1, 0);
      tick("ovf_call");
    end
    check("ovf_flag", 32'(ras_overflow), 1);
    set_in(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick("ovf_ret");
      check("ovf_ret_pc", 32'(pc), 6 - i);
    end
    tick("unf_ret");
    check("unf_pc", 32'(pc), 4);
    check("unf_flag", 32'(ras_underflow), 1);

    // Stall masks everything; release resolves jump over branch
    set_in(0, 1, 0, 0, 0, 77, 0); tick("st_setup");
    set_in(1, 1, 1, 0, 1, 300, 3);
    for (int i = 0; i < 3; i++) tick("stall");
    check("stall_pc", 32'(pc), 77);
    set_in(0, 0, 0, 1, 1, 400, 3); tick("st_release");
    check("st_rel_pc", 32'(pc), 400);

    // Swap, then reset beats a concurrent call
    rst = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0); tick("sw_reset");
    rst = 1'b0;
    set_in(0, 0, 0, 1, 0, 29, 0); tick("sw_setup");
    set_in(0, 1, 0, 0, 0, 50, 0); tick("sw_call");
    set_in(0, 1, 1, 0, 0, 0, 0);  tick("swap");
    check("swap_pc", 32'(pc), 30);
    check("swap_top", 32'(ras_top), 51);
    check("swap_cnt", 32'(ras_count), 1);
    rst = 1'b1; set_in(0, 1, 0, 0, 0, 123, 0); tick("rst_call");
    check("rst_call_cnt", 32'(ras_count), 0);
    rst = 1'b0;
    set_in(0, 1, 1, 0, 0, 0, 0); tick("swap_empty");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      set_in($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) == 0, int'($urandom), int'($urandom));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
